// File: rtl/ext_pipe.sv
// Immediate extender: decodes in_op into a sign/zero/upper/shifted OUT_W result, queued in a DEPTH-entry FIFO.
// Latency 1 cycle into an empty buffer; in_ready drops when the buffer is full and never looks at out_ready.
module ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_op,
  input  logic [IN_W-1:0]          in_imm,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_imm,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PAD_W = OUT_W - IN_W;

  typedef enum logic [2:0] {
    OP_LOGIC  = 3'd0,
    OP_ARITH  = 3'd1,
    OP_UPPER  = 3'd2,
    OP_BRANCH = 3'd3,
    OP_SHIFT  = 3'd4
  } op_e;

  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] ext_imm;
  logic             ext_err;

  logic [OUT_W-1:0] mem_imm [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];
  logic             mem_err [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  assign zext = {{PAD_W{1'b0}}, in_imm};
  assign sext = {{PAD_W{in_imm[IN_W-1]}}, in_imm};

  always_comb begin
    ext_imm = '0;
    ext_err = 1'b0;
    case (in_op)
      OP_LOGIC:  ext_imm = zext;
      OP_ARITH:  ext_imm = sext;
      OP_UPPER:  ext_imm = {in_imm, {PAD_W{1'b0}}};
      OP_BRANCH: ext_imm = sext << 2;
      OP_SHIFT:  ext_imm = zext << 2;
      default:   ext_err = 1'b1;
    endcase
  end

  // in_ready is held low through reset, otherwise it is a pure function of count.
  assign in_ready  = rst_n && (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_imm[wr_ptr] <= ext_imm;
      mem_tag[wr_ptr] <= in_tag;
      mem_err[wr_ptr] <= ext_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset, so the head is masked to zero whenever nothing is held.
  assign out_imm = out_valid ? mem_imm[rd_ptr] : '0;
  assign out_tag = out_valid ? mem_tag[rd_ptr] : '0;
  assign out_err = out_valid ? mem_err[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_ext_pipe.sv
// Directed bench for ext_pipe: driver pushes expected results into a scoreboard queue, a monitor pops on each delivery.
module tb_ext_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [15:0] in_imm;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [4:0]  out_tag;
  logic        out_err;
  logic [1:0]  count;

  typedef struct {
    logic [31:0] imm;
    logic [4:0]  tag;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   cyc        = 0;

  ext_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_imm(in_imm), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_tag(out_tag), .out_err(out_err),
    .count(count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the head on every delivery and checks stability while stalled.
  logic        stalled = 1'b0;
  logic [31:0] held_imm;
  logic [4:0]  held_tag;
  logic        held_err;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) begin
      if (stalled) begin
        check("hold_imm", out_imm, held_imm);
        check("hold_tag", {27'd0, out_tag}, {27'd0, held_tag});
        check("hold_err", {31'd0, out_err}, {31'd0, held_err});
      end
      if (out_ready) begin
        stalled = 1'b0;
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_out: got imm %h tag %0d with empty scoreboard", out_imm, out_tag);
        end else begin
          e = sb.pop_front();
          check("out_imm", out_imm, e.imm);
          check("out_tag", {27'd0, out_tag}, {27'd0, e.tag});
          check("out_err", {31'd0, out_err}, {31'd0, e.err});
        end
      end else begin
        stalled  = 1'b1;
        held_imm = out_imm;
        held_tag = out_tag;
        held_err = out_err;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  // Presents one request from posedge+1 until accepted; leaves the bus idle one step after the accepting edge.
  task automatic push(input logic [2:0] op, input logic [15:0] imm, input logic [4:0] tag,
                      input logic [31:0] eimm, input logic eerr);
    exp_t e;
    bit   ok = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_imm   = imm;
    in_tag   = tag;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      else @(posedge clk);
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL push_timeout: in_ready stayed 0, expected 1");
    end else begin
      e.imm = eimm; e.tag = tag; e.err = eerr;
      sb.push_back(e);
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    check("drain_left", sb.size(), 0);
    #1;
  endtask

  initial begin
    exp_t e;
    int   t0;
    rst_n = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_imm = 16'h0; in_tag = 5'd0; out_ready = 1'b1;

    // reset state
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("rst_count",     {30'd0, count},     32'd0);
    check("rst_out_imm",   out_imm,            32'd0);
    check("rst_out_tag",   {27'd0, out_tag},   32'd0);
    check("rst_out_err",   {31'd0, out_err},   32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("first_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // one-cycle latency into an empty buffer
    push(3'd1, 16'h8000, 5'd3, 32'hFFFF8000, 1'b0);
    @(negedge clk);
    check("lat_out_valid", {31'd0, out_valid}, 32'd1);
    check("lat_count",     {30'd0, count},     32'd1);
    @(posedge clk); #1;

    // each mode plus illegal encodings
    push(3'd0, 16'h8000, 5'd1,  32'h00008000, 1'b0);
    push(3'd2, 16'h1234, 5'd2,  32'h12340000, 1'b0);
    push(3'd3, 16'hFFFF, 5'd4,  32'hFFFFFFFC, 1'b0);
    push(3'd4, 16'hC000, 5'd5,  32'h00030000, 1'b0);
    push(3'd6, 16'hABCD, 5'd7,  32'h00000000, 1'b1);
    push(3'd1, 16'h7FFF, 5'd8,  32'h00007FFF, 1'b0);
    push(3'd3, 16'h4001, 5'd9,  32'h00010004, 1'b0);
    push(3'd5, 16'h0001, 5'd31, 32'h00000000, 1'b1);
    push(3'd7, 16'hFFFF, 5'd0,  32'h00000000, 1'b1);
    drain();

    // inputs ignored while in_valid is low
    in_op = 3'd2; in_imm = 16'hDEAD; in_tag = 5'd11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("idle_count", {30'd0, count}, 32'd0);
    @(posedge clk); #1;

    // backpressure: fill, hold, then release with a waiting third request
    out_ready = 1'b0;
    push(3'd0, 16'h0011, 5'd1, 32'h00000011, 1'b0);
    push(3'd0, 16'h0022, 5'd2, 32'h00000022, 1'b0);
    @(negedge clk);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    check("full_count",    {30'd0, count},    32'd2);
    check("full_head_imm", out_imm,           32'h00000011);
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = 3'd2; in_imm = 16'h0033; in_tag = 5'd3;
    out_ready = 1'b1;
    e.imm = 32'h00330000; e.tag = 5'd3; e.err = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    check("full_deliver_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("after_deliver_count",    {30'd0, count},    32'd1);
    check("after_deliver_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("accept_deliver_count", {30'd0, count}, 32'd1);
    drain();

    // sustained throughput: eight results in eight cycles
    t0 = cyc;
    for (int i = 0; i < 8; i++)
      push(3'd0, 16'(i * 3), 5'(i), {16'd0, 16'(i * 3)}, 1'b0);
    check("throughput_cycles", cyc - t0, 8);
    drain();

    // reset mid-operation discards buffered entries
    out_ready = 1'b0;
    push(3'd1, 16'h9000, 5'd12, 32'hFFFF9000, 1'b0);
    push(3'd1, 16'h9001, 5'd13, 32'hFFFF9001, 1'b0);
    @(negedge clk);
    check("pre_rst_count", {30'd0, count}, 32'd2);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_count",     {30'd0, count},     32'd0);
    check("mid_rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("mid_rst_out_imm",   out_imm,            32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("post_rst_count",     {30'd0, count},     32'd0);
    @(posedge clk); #1;
    push(3'd2, 16'hBEEF, 5'd21, 32'hBEEF0000, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
